// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: registered request side, returned read data and completion.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ready
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues byte/word data-memory accesses, stalls upstream while one is
// outstanding, aborts after TIMEOUT silent cycles, and registers the MEM/WB entry.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_load,
    input  logic              id_mem_write,
    input  logic              id_mem_size,
    input  logic              id_mem_enable,
    input  logic              rf_enable,
    input  logic [ADDR_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              mem_stall,
    mem_access_stage_if.master dm,
    output logic              wb_valid,
    output logic              wb_rf_enable,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_align_err,
    output logic              mem_bus_err
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_store, r_byte, r_align, r_rf_en;
    logic [1:0]        r_lane;
    logic [REG_W-1:0]  r_rd;
    logic [ADDR_W-1:0] r_result;

    logic              r_dm_req, r_dm_we;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [DATA_W-1:0] r_dm_wdata;
    logic [3:0]        r_dm_be;

    logic              r_wb_valid, r_wb_rf;
    logic [REG_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_align_err, r_bus_err;

    logic              w_store;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_rbyte;
    logic [DATA_W-1:0] w_load_data;
    logic              w_expired;

    // A write wins over a simultaneous load flag; anything that is not a write is a read.
    always_comb begin
        w_store = 1'b0;
        case ({id_mem_write, id_load})
            2'b10, 2'b11: w_store = 1'b1;
            2'b01:        w_store = 1'b0;
            default:      w_store = 1'b0;
        endcase
    end

    assign w_lane      = ex_result[1:0];
    assign w_be        = id_mem_size ? (4'b0001 << w_lane) : 4'b1111;
    assign w_wdata     = id_mem_size ? {4{ex_store_data[7:0]}} : ex_store_data;
    assign w_rbyte     = dm.dm_rdata[{r_lane, 3'b000} +: 8];
    assign w_load_data = r_byte ? {{(DATA_W-8){1'b0}}, w_rbyte} : dm.dm_rdata;
    assign w_expired   = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // The expiring cycle releases the stall so the failed instruction leaves EX/MEM.
    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        case (r_state)
            IDLE: begin
                mem_stall = id_mem_enable;
                if (id_mem_enable) w_next = ACCESS;
            end
            ACCESS: begin
                mem_stall = !dm.dm_ready && !w_expired;
                if (dm.dm_ready || w_expired) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (!reset) mem_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_store     <= 1'b0;
            r_byte      <= 1'b0;
            r_align     <= 1'b0;
            r_rf_en     <= 1'b0;
            r_lane      <= 2'b00;
            r_rd        <= '0;
            r_result    <= '0;
            r_dm_req    <= 1'b0;
            r_dm_we     <= 1'b0;
            r_dm_addr   <= '0;
            r_dm_wdata  <= '0;
            r_dm_be     <= 4'b0000;
            r_wb_valid  <= 1'b0;
            r_wb_rf     <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (id_mem_enable) begin
                        r_store    <= w_store;
                        r_byte     <= id_mem_size;
                        r_align    <= !id_mem_size && (w_lane != 2'b00);
                        r_rf_en    <= rf_enable;
                        r_lane     <= w_lane;
                        r_rd       <= ex_rd;
                        r_result   <= ex_result;
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= w_store;
                        r_dm_addr  <= {ex_result[ADDR_W-1:2], 2'b00};
                        r_dm_wdata <= w_wdata;
                        r_dm_be    <= w_be;
                        r_wb_valid <= 1'b0;
                        r_wb_rf    <= 1'b0;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_wb_rf    <= rf_enable;
                        r_wb_rd    <= ex_rd;
                        r_wb_data  <= DATA_W'(ex_result);
                    end
                end
                ACCESS: begin
                    if (dm.dm_ready) begin
                        r_dm_req    <= 1'b0;
                        r_wb_valid  <= 1'b1;
                        r_wb_rf     <= r_rf_en;
                        r_wb_rd     <= r_rd;
                        r_wb_data   <= r_store ? DATA_W'(r_result) : w_load_data;
                        r_align_err <= r_align;
                    end else if (w_expired) begin
                        r_dm_req   <= 1'b0;
                        r_wb_valid <= 1'b0;
                        r_wb_rf    <= 1'b0;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_wb_valid <= 1'b0;
                        r_wb_rf    <= 1'b0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign dm.dm_req     = r_dm_req;
    assign dm.dm_we      = r_dm_we;
    assign dm.dm_addr    = r_dm_addr;
    assign dm.dm_wdata   = r_dm_wdata;
    assign dm.dm_be      = r_dm_be;
    assign wb_valid      = r_wb_valid;
    assign wb_rf_enable  = r_wb_rf;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign mem_align_err = r_align_err;
    assign mem_bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed ops, a transaction-level expectation queue checked every
// cycle, and literal expectations for the headline cases.
module tb_mem_access_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_load = 1'b0, id_mem_write = 1'b0, id_mem_size = 1'b0;
    logic        id_mem_enable = 1'b0, rf_enable = 1'b0;
    logic [31:0] ex_result = '0, ex_store_data = '0;
    logic [3:0]  ex_rd = '0;
    logic        mem_stall, wb_valid, wb_rf_enable, mem_align_err, mem_bus_err;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) dm ();

    mem_access_stage #(.ADDR_W(32), .DATA_W(32), .REG_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_load(id_load), .id_mem_write(id_mem_write), .id_mem_size(id_mem_size),
        .id_mem_enable(id_mem_enable), .rf_enable(rf_enable),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .mem_stall(mem_stall), .dm(dm),
        .wb_valid(wb_valid), .wb_rf_enable(wb_rf_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_align_err(mem_align_err), .mem_bus_err(mem_bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with no expectation pending", name);
    endtask

    typedef struct {
        logic        rf;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        align;
        logic        berr;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    wb_t  wb_q[$];
    acc_t acc_q[$];
    bit   chk_on = 0;
    logic prev_req = 1'b0;
    logic        seen_we;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    // Every WB-side event must match the oldest expected entry; every request cycle must match
    // the oldest expected access, retired when dm_req falls.
    always @(negedge clk) begin : cmp
        wb_t  e;
        acc_t a;
        if (chk_on) begin
            if (wb_valid || mem_bus_err) begin
                if (wb_q.size() == 0) fail_now("wb_unexpected");
                else begin
                    e = wb_q.pop_front();
                    check("wb_valid", wb_valid, !e.berr);
                    check("bus_err", mem_bus_err, e.berr);
                    check("align_err", mem_align_err, e.align);
                    if (!e.berr) begin
                        check("wb_rf_enable", wb_rf_enable, e.rf);
                        check("wb_rd", wb_rd, e.rd);
                        check("wb_data", wb_data, e.data);
                    end
                end
            end else begin
                check("align_err_idle", mem_align_err, 1'b0);
            end
            if (dm.dm_req) begin
                if (acc_q.size() == 0) fail_now("dm_req_unexpected");
                else begin
                    a = acc_q[0];
                    check("dm_we", dm.dm_we, a.we);
                    check("dm_addr", dm.dm_addr, a.addr);
                    check("dm_be", dm.dm_be, a.be);
                    check("dm_wdata", dm.dm_wdata, a.wdata);
                end
                seen_we    = dm.dm_we;
                seen_addr  = dm.dm_addr;
                seen_be    = dm.dm_be;
                seen_wdata = dm.dm_wdata;
            end else if (prev_req && acc_q.size() > 0) begin
                void'(acc_q.pop_front());
            end
            prev_req = dm.dm_req;
        end
    end

    task automatic alu_op(input logic rf, input logic [3:0] rd, input logic [31:0] res);
        wb_t e;
        id_mem_enable = 1'b0;
        rf_enable     = rf;
        ex_rd         = rd;
        ex_result     = res;
        e.rf = rf; e.rd = rd; e.data = res; e.align = 1'b0; e.berr = 1'b0;
        wb_q.push_back(e);
        #1 check("alu_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
    endtask

    // lat = ACCESS cycles without dm_ready before the ready cycle; lat >= TO never answers.
    task automatic mem_op(input logic ld, input logic wr, input logic sz,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic rf, input logic [3:0] rd, input int lat,
                          input logic [31:0] rdata, output int stalls);
        acc_t a;
        wb_t  e;
        logic [1:0] ln;
        ln = addr[1:0];
        a.we    = wr;
        a.addr  = addr & ~32'h3;
        a.be    = sz ? (4'b0001 << ln) : 4'hF;
        a.wdata = sz ? {4{sdata[7:0]}} : sdata;
        acc_q.push_back(a);
        e.rf    = rf;
        e.rd    = rd;
        e.berr  = (lat >= TO);
        e.align = !e.berr && !sz && (ln != 2'b00);
        e.data  = wr ? addr : (sz ? ((rdata >> (8 * ln)) & 32'hFF) : rdata);
        wb_q.push_back(e);
        id_mem_enable = 1'b1; id_load = ld; id_mem_write = wr; id_mem_size = sz;
        ex_result = addr; ex_store_data = sdata; rf_enable = rf; ex_rd = rd;
        dm.dm_ready = 1'b0; dm.dm_rdata = 32'hBAD0BAD0;
        stalls = 0;
        @(negedge clk) stalls += int'(mem_stall);
        @(posedge clk); #1;
        for (int k = 1; k <= TO; k++) begin
            if (k == lat + 1) begin
                dm.dm_ready = 1'b1;
                dm.dm_rdata = rdata;
            end
            @(negedge clk) stalls += int'(mem_stall);
            @(posedge clk); #1;
            if (dm.dm_ready) break;
        end
        dm.dm_ready = 1'b0;
        dm.dm_rdata = 32'hBAD0BAD0;
        id_mem_enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int st;
        acc_t a;
        id_mem_enable = 1'b1;
        ex_result = 32'h100;
        dm.dm_ready = 1'b0;
        dm.dm_rdata = '0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_wb_valid", wb_valid, 1'b0);
            check("rst_dm_req", dm.dm_req, 1'b0);
            check("rst_stall", mem_stall, 1'b0);
            check("rst_wb_data", wb_data, 32'h0);
            check("rst_dm_be", dm.dm_be, 4'h0);
            check("rst_errs", {mem_align_err, mem_bus_err}, 2'b00);
        end
        chk_on = 1;
        reset  = 1'b1;

        alu_op(1'b1, 4'd3, 32'h1234);
        check("lit_alu_valid", wb_valid, 1'b1);
        check("lit_alu_rd", wb_rd, 4'd3);
        check("lit_alu_data", wb_data, 32'h1234);

        mem_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 4'd5, 3, 32'hDEADBEEF, st);
        check("lit_ldw_stalls", st, 4);
        check("lit_ldw_data", wb_data, 32'hDEADBEEF);
        check("lit_ldw_valid", wb_valid, 1'b1);
        check("lit_ldw_addr", seen_addr, 32'h100);
        check("lit_ldw_be", seen_be, 4'hF);
        check("lit_ldw_we", seen_we, 1'b0);

        mem_op(1'b0, 1'b1, 1'b1, 32'h103, 32'h123456AB, 1'b0, 4'd0, 0, 32'h0, st);
        check("lit_stb_stalls", st, 1);
        check("lit_stb_we", seen_we, 1'b1);
        check("lit_stb_be", seen_be, 4'b1000);
        check("lit_stb_wdata", seen_wdata, 32'hABABABAB);

        mem_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 1'b1, 4'd7, 0, 32'h11223344, st);
        check("lit_ldb2_data", wb_data, 32'h00000022);
        mem_op(1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 1'b1, 4'd8, 1, 32'h11223344, st);
        check("lit_ldb1_data", wb_data, 32'h00000033);

        mem_op(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b1, 4'd2, 1, 32'hCAFEF00D, st);
        check("lit_mis_addr", seen_addr, 32'h100);
        check("lit_mis_err", mem_align_err, 1'b1);
        check("lit_mis_data", wb_data, 32'hCAFEF00D);
        alu_op(1'b0, 4'd1, 32'h55);
        check("lit_mis_err_clear", mem_align_err, 1'b0);

        mem_op(1'b1, 1'b1, 1'b0, 32'h200, 32'h0BADCAFE, 1'b0, 4'd0, 2, 32'h77777777, st);
        check("lit_both_we", seen_we, 1'b1);
        check("lit_both_wdata", seen_wdata, 32'h0BADCAFE);
        check("lit_both_data", wb_data, 32'h200);

        mem_op(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1, 4'd9, TO, 32'h0, st);
        check("lit_to_stalls", st, TO);
        check("lit_to_req", dm.dm_req, 1'b0);
        check("lit_to_buserr", mem_bus_err, 1'b1);
        check("lit_to_valid", wb_valid, 1'b0);
        alu_op(1'b1, 4'd4, 32'hA5);
        check("lit_to_buserr_clear", mem_bus_err, 1'b0);
        check("lit_to_next_valid", wb_valid, 1'b1);

        // Abandon an access with reset; a late dm_ready must not create a WB entry.
        a.we = 1'b0; a.addr = 32'h400; a.be = 4'hF; a.wdata = 32'h0;
        acc_q.push_back(a);
        id_mem_enable = 1'b1; id_load = 1'b1; id_mem_write = 1'b0; id_mem_size = 1'b0;
        ex_result = 32'h400; ex_store_data = 32'h0;
        @(posedge clk); #1;
        check("lit_rst_req_up", dm.dm_req, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1 check("lit_rst_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        check("lit_rst_req_down", dm.dm_req, 1'b0);
        check("lit_rst_valid", wb_valid, 1'b0);
        reset = 1'b1;
        dm.dm_ready = 1'b1;
        dm.dm_rdata = 32'h55555555;
        alu_op(1'b1, 4'd6, 32'h77);
        dm.dm_ready = 1'b0;
        check("lit_late_ready_data", wb_data, 32'h77);

        @(negedge clk); #1;
        chk_on = 0;
        check("wb_queue_drained", wb_q.size(), 0);
        check("acc_queue_drained", acc_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access (MEM) stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered EX/MEM control bits (load, write, size, enable, rf_enable) together with the address/result, store data and destination register.
- Performs byte or word accesses to the data memory over a req/ready handshake, stalls the upstream pipeline while an access is outstanding, and drives the registered MEM/WB outputs consumed by writeback.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- REG_W, 4, destination register index width.
- TIMEOUT, 16, max ACCESS cycles without dm_ready before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- id_load  in  1  EX/MEM: operation is a load.
- id_mem_write  in  1  EX/MEM: operation is a store.
- id_mem_size  in  1  EX/MEM: 0=word, 1=byte.
- id_mem_enable  in  1  EX/MEM: memory access requested.
- rf_enable  in  1  EX/MEM: destination register write enable.
- ex_result  in  ADDR_W  ALU result; memory address when id_mem_enable=1.
- ex_store_data  in  DATA_W  store data.
- ex_rd  in  REG_W  destination register.
- mem_stall  out  1  hold EX/MEM and earlier stages (combinational).
- dm_req  out  1  memory request.
- dm_we  out  1  memory write.
- dm_addr  out  ADDR_W  word-aligned memory address.
- dm_wdata  out  DATA_W  write data.
- dm_be  out  4  byte enables.
- dm_rdata  in  DATA_W  read data, valid with dm_ready.
- dm_ready  in  1  memory completion.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rf_enable  out  1  register write enable to WB.
- wb_rd  out  REG_W  destination register to WB.
- wb_data  out  DATA_W  writeback data.
- mem_align_err  out  1  one-cycle pulse: misaligned word access.
- mem_bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:
Reset:
- reset=0 at an edge sets state=IDLE and clears the timeout counter.
- It drives all registered outputs (wb_*, dm_*, mem_align_err, mem_bus_err) to 0.
- Reset mid-ACCESS abandons the access; a dm_ready arriving after reset is ignored.

FSM states: IDLE, ACCESS.

IDLE, id_mem_enable=0 (pass-through):
- At the next edge: wb_valid=1, wb_rf_enable=rf_enable, wb_rd=ex_rd, wb_data=ex_result.
- mem_stall=0.

IDLE, id_mem_enable=1:
- mem_stall=1 combinationally.
- At the edge: capture the operation and go to ACCESS.
- wb_valid=0 at that edge (bubble).
- Registered dm_req=1 from the first ACCESS cycle onward.

Operation decode:
- id_mem_write=1 means store; id_mem_write has priority over id_load.
- id_mem_write=0 means read, regardless of id_load.

ACCESS:
- dm_req, dm_we, dm_addr, dm_wdata and dm_be are held stable until completion.
- mem_stall = !dm_ready.
- On dm_ready=1: dm_req drops to 0 at that edge; the WB entry is registered; state returns to IDLE.
- Upstream advances on that same edge, so minimum latency is 2 cycles per memory op.
- Each cycle without dm_ready increments the counter. When the counter reaches TIMEOUT-1 without dm_ready:
  - go to IDLE and drop dm_req;
  - wb_valid=0 and mem_bus_err=1 for one cycle;
  - mem_stall=0 in that cycle.

Address and lanes:
- dm_addr = {ex_result[ADDR_W-1:2], 2'b00}.
- Word access: dm_be=4'b1111, dm_wdata=ex_store_data.
- Word access with ex_result[1:0]!=0: the access still proceeds aligned, and mem_align_err pulses with the WB entry.
- Byte access: dm_be = 1<<ex_result[1:0]; dm_wdata = ex_store_data[7:0] replicated into all 4 lanes.

Writeback data:
- Word read: wb_data=dm_rdata.
- Byte read: wb_data = zero-extended lane addr[1:0] of dm_rdata (little-endian).
- Store: wb_data=captured ex_result, wb_rf_enable=captured rf_enable.

Signals valid only with dm_ready:
- dm_rdata is sampled only when dm_ready=1.
- dm_ready in IDLE is ignored.

Error pulses:
- mem_align_err and mem_bus_err are 0 in every cycle except their defined pulse cycles.

Test Plan:
- Reset held 0 for 2 cycles with id_mem_enable=1 -> all outputs 0, mem_stall=0 while in reset, dm_req never rises.
- ALU op: id_mem_enable=0, rf_enable=1, ex_result=0x1234, ex_rd=3 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x1234, mem_stall=0.
- Word load addr 0x100, dm_ready after 3 ACCESS cycles, dm_rdata=0xDEADBEEF -> mem_stall high 4 cycles, dm_addr=0x100, dm_be=1111, dm_we=0, then wb_data=0xDEADBEEF, wb_valid=1.
- Byte store addr 0x103, data 0xAB, immediate ready -> dm_we=1, dm_be=1000, dm_wdata=0xABABABAB; byte load addr 0x102 with rdata 0x11223344 -> wb_data=0x00000022.
- Word load addr 0x102 -> dm_addr=0x100, mem_align_err=1 for exactly the WB cycle; id_load=1 and id_mem_write=1 together -> store performed.
- No dm_ready for TIMEOUT cycles -> dm_req falls, mem_bus_err pulses once, wb_valid=0, state IDLE; reset asserted mid-ACCESS -> IDLE, later dm_ready produces no WB entry.
